// File: rtl/ipsxe_floating_point_invsqrt_horner_ctrl_v1_0.sv
// Horner-scheme controller for the inverse-square-root polynomial:
// P = a0 - d*(a1 - d*(... - d*a6)), one shared multiplier, coefficients fetched one per cycle.
module ipsxe_floating_point_invsqrt_horner_ctrl_v1_0 #(
  parameter int DX_W   = 16,
  parameter int COEF_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [7:0]        i_x_hi8,
  input  logic [DX_W-1:0]   i_dx,
  output logic [7:0]        o_x_hi8,
  output logic [2:0]        o_coef_sel,
  input  logic [COEF_W-1:0] i_coef,
  input  logic              i_abort,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [COEF_W-1:0] o_result,
  output logic              o_sat,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          xHi8_q, xHi8_d;
  logic [DX_W-1:0]     dx_q, dx_d;
  logic [COEF_W-1:0]   acc_q, acc_d;
  logic [2:0]          k_q, k_d;
  logic                sat_q, sat_d;
  logic [2:0]          coefSel;

  logic [COEF_W+DX_W-1:0] mulFull;
  logic [COEF_W-1:0]      prod;

  // d is a pure fraction, so dropping DX_W low bits keeps the product in accumulator scale
  assign mulFull = {{DX_W{1'b0}}, acc_q} * {{COEF_W{1'b0}}, dx_q};
  assign prod    = mulFull[COEF_W+DX_W-1:DX_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      xHi8_q  <= '0;
      dx_q    <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xHi8_q  <= xHi8_d;
      dx_q    <= dx_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xHi8_d  = xHi8_q;
    dx_d    = dx_q;
    acc_d   = acc_q;
    k_d     = k_q;
    sat_d   = sat_q;
    coefSel = 3'd0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          xHi8_d  = i_x_hi8;
          dx_d    = i_dx;
          sat_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        coefSel = 3'd6;
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = i_coef;
          k_d     = 3'd5;
          state_d = CALC;
        end
      end
      CALC: begin
        coefSel = k_q;
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          // a negative partial sum cannot be represented, so clamp and flag it
          if (i_coef < prod) begin
            acc_d = '0;
            sat_d = 1'b1;
          end else begin
            acc_d = i_coef - prod;
          end
          if (k_q == 3'd0) begin
            state_d = DONE;
          end else begin
            k_d = k_q - 3'd1;
          end
        end
      end
      DONE: begin
        if (i_abort || i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready    = (state_q == IDLE);
  assign o_busy     = (state_q != IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_coef_sel = coefSel;
  assign o_x_hi8    = xHi8_q;
  assign o_result   = acc_q;
  assign o_sat      = sat_q;

endmodule
